// File: rtl/pipe_delay_line.sv
// pipe_delay_line: multi-stage operand/result register chain with a
// run-time selectable tap. Each stage carries a data word and a valid bit;
// a saturating fill counter records how many enabled edges have passed
// since the last reset/flush so the selected tap can report whether it
// holds fresh data. LAT=0 bypasses every register.
module pipe_delay_line #(
    parameter int              WIDTH     = 18,
    parameter int              MAX_DEPTH = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int              LW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] DIN,
    input  logic             VIN,
    input  logic [LW-1:0]    LAT,
    output logic [WIDTH-1:0] DOUT,
    output logic             VOUT,
    output logic             PRIMED
);

    localparam logic [LW-1:0] MAX_L = LW'(MAX_DEPTH);

    // Stage 1 is the register fed directly by DIN; stage MAX_DEPTH is the oldest.
    logic [WIDTH-1:0] d [1:MAX_DEPTH];
    logic             v [1:MAX_DEPTH];
    logic [LW-1:0]    fill;
    logic [LW-1:0]    sel;

    // LAT values beyond the physical depth select the deepest stage.
    function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] lat);
        return (lat > MAX_L) ? MAX_L : lat;
    endfunction

    // Data/valid shift chain: clear on reset or flush, shift on enable, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= MAX_DEPTH; i++) begin
                d[i] <= RST_VAL;
                v[i] <= 1'b0;
            end
        end else if (FLUSH) begin
            for (int i = 1; i <= MAX_DEPTH; i++) begin
                d[i] <= RST_VAL;
                v[i] <= 1'b0;
            end
        end else if (EN) begin
            d[1] <= DIN;
            v[1] <= VIN;
            for (int i = 2; i <= MAX_DEPTH; i++) begin
                d[i] <= d[i-1];
                v[i] <= v[i-1];
            end
        end
    end

    // Fill counter: enabled edges since clear, saturating at the chain depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
        end else if (FLUSH) begin
            fill <= '0;
        end else if (EN && (fill != MAX_L)) begin
            fill <= fill + LW'(1);
        end
    end

    // Tap mux: bypass at L=0, otherwise the selected stage and its freshness.
    always_comb begin
        sel    = clamp_lat(LAT);
        DOUT   = DIN;
        VOUT   = VIN;
        PRIMED = 1'b1;
        for (int i = 1; i <= MAX_DEPTH; i++) begin
            if (sel == LW'(i)) begin
                DOUT   = d[i];
                VOUT   = v[i];
                PRIMED = (fill >= sel);
            end
        end
    end

endmodule

// File: tb/tb_pipe_delay_line.sv
// Bench for pipe_delay_line: directed scenarios followed by a randomized
// phase, every output compared against a history-queue reference model.
module tb_pipe_delay_line;

    localparam int               WIDTH     = 18;
    localparam int               MAX_DEPTH = 4;
    localparam int               LW        = $clog2(MAX_DEPTH + 1);
    localparam logic [WIDTH-1:0] RST_VAL   = 18'h3C5A5;

    logic             clk = 1'b0;
    logic             rst;
    logic             EN;
    logic             FLUSH;
    logic [WIDTH-1:0] DIN;
    logic             VIN;
    logic [LW-1:0]    LAT;
    logic [WIDTH-1:0] DOUT;
    logic             VOUT;
    logic             PRIMED;

    int checks   = 0;
    int failures = 0;

    // Reference: samples accepted since the last clear, newest first.
    logic [WIDTH-1:0] hd [$];
    logic             hv [$];

    logic [WIDTH-1:0] prev_dout;

    pipe_delay_line #(
        .WIDTH    (WIDTH),
        .MAX_DEPTH(MAX_DEPTH),
        .RST_VAL  (RST_VAL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .EN    (EN),
        .FLUSH (FLUSH),
        .DIN   (DIN),
        .VIN   (VIN),
        .LAT   (LAT),
        .DOUT  (DOUT),
        .VOUT  (VOUT),
        .PRIMED(PRIMED)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        hd.delete();
        hv.delete();
    endtask

    task automatic model_edge();
        if (rst || FLUSH) begin
            model_clear();
        end else if (EN) begin
            hd.push_front(DIN);
            hv.push_front(VIN);
            if (hd.size() > MAX_DEPTH) begin
                void'(hd.pop_back());
                void'(hv.pop_back());
            end
        end
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int               l;
        logic [WIDTH-1:0] ed;
        logic             ev;
        logic             ep;
        l = (int'(LAT) > MAX_DEPTH) ? MAX_DEPTH : int'(LAT);
        if (l == 0) begin
            ed = DIN; ev = VIN; ep = 1'b1;
        end else if (hd.size() >= l) begin
            ed = hd[l-1]; ev = hv[l-1]; ep = 1'b1;
        end else begin
            ed = RST_VAL; ev = 1'b0; ep = 1'b0;
        end
        chk({tag, "_dout"}, DOUT, ed);
        chk({tag, "_vout"}, WIDTH'(VOUT), WIDTH'(ev));
        chk({tag, "_primed"}, WIDTH'(PRIMED), WIDTH'(ep));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; EN = 1'b0; FLUSH = 1'b0; DIN = '0; VIN = 1'b0; LAT = LW'(3);
        model_clear();
        @(posedge clk);
        #1;
        check_all("in_reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all("after_reset");

        // Reset/fill: LAT=3 stream 1,2,3,...
        EN = 1'b1; VIN = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            DIN = WIDTH'(k);
            tick("fill");
        end
        chk("fill_last_value", DOUT, WIDTH'(6));

        // Stall with LAT=2
        LAT = LW'(2);
        DIN = WIDTH'(10); tick("stall_load10");
        DIN = WIDTH'(11); tick("stall_load11");
        EN = 1'b0; DIN = WIDTH'(12);
        for (int k = 0; k < 3; k++) begin
            VIN = k[0];
            tick("stall_hold");
            chk("stall_frozen", DOUT, WIDTH'(10));
        end
        EN = 1'b1; VIN = 1'b1;
        tick("stall_resume11");
        chk("stall_resume_val11", DOUT, WIDTH'(11));
        DIN = WIDTH'(13);
        tick("stall_resume12");
        chk("stall_resume_val12", DOUT, WIDTH'(12));

        // Flush priority over EN, LAT=4
        LAT = LW'(4);
        for (int k = 0; k < 3; k++) begin
            DIN = WIDTH'(100 + k);
            tick("pre_flush");
        end
        FLUSH = 1'b1; DIN = WIDTH'(77);
        tick("flush_edge");
        chk("flush_dout_rst", DOUT, RST_VAL);
        FLUSH = 1'b0;
        for (int k = 0; k < 5; k++) begin
            DIN = WIDTH'(200 + k);
            tick("post_flush");
        end

        // Bypass and clamp
        LAT = '0; DIN = WIDTH'(18'h2A); VIN = 1'b1;
        #1;
        check_all("bypass");
        chk("bypass_const", DOUT, WIDTH'(18'h2A));
        LAT = LW'(7);
        #1;
        check_all("clamp7");
        prev_dout = DOUT;
        LAT = LW'(4);
        #1;
        check_all("clamp4");
        chk("clamp_equal", DOUT, prev_dout);

        // Runtime LAT change 1 -> 4 on a primed stream
        FLUSH = 1'b1; tick("flush2");
        FLUSH = 1'b0; LAT = LW'(1);
        for (int k = 0; k < 6; k++) begin
            DIN = WIDTH'(20 + k);
            tick("lat_stream");
        end
        prev_dout = DOUT;
        LAT = LW'(4);
        #1;
        check_all("lat_switch");
        chk("lat_switch_minus3", DOUT, prev_dout - WIDTH'(3));

        // Async reset between edges while VOUT=1
        LAT = LW'(1); VIN = 1'b1; DIN = WIDTH'(55);
        tick("pre_areset");
        chk("pre_areset_vout", WIDTH'(VOUT), WIDTH'(1));
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_all("areset");
        #1;
        rst = 1'b0;
        DIN = WIDTH'(66);
        tick("areset_release");
        chk("areset_first_load", DOUT, WIDTH'(66));

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            EN    = ($urandom_range(0, 3) != 0);
            FLUSH = ($urandom_range(0, 19) == 0);
            VIN   = $urandom_range(0, 1) == 1;
            DIN   = WIDTH'($urandom);
            LAT   = LW'($urandom_range(0, 7));
            #1;
            check_all("rand_comb");
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                model_clear();
                #1;
                check_all("rand_areset");
                rst = 1'b0;
            end
            tick("rand_edge");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_delay_line.md
# pipe_delay_line

Parametrised multi-stage pipeline register with a runtime-selectable tap, per-stage valid tracking, clock-enable stall and synchronous flush. It generalises the single optional register stage used on the DSP slice operand and result paths (A/B/C/D/M/P) to 0..MAX_DEPTH stages selectable at run time. It also reports when the selected tap holds data that entered after the last reset or flush. It sits between operand sources and the pre-adder/multiplier/post-adder datapath, one instance per operand.

## Interface
Parameters:
- WIDTH, 18, data width in bits (1..64)
- MAX_DEPTH, 4, number of physical register stages (1..32)
- RST_VAL, 0, value loaded into every data stage on reset and flush (WIDTH bits)
- LW, $clog2(MAX_DEPTH+1), width of LAT; derived, not overridden

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- EN  in  1  clock enable; low = stall, every stage holds
- FLUSH  in  1  synchronous clear, priority over EN
- DIN  in  WIDTH  data in
- VIN  in  1  valid qualifier for DIN
- LAT  in  LW  selected latency in cycles, 0..MAX_DEPTH
- DOUT  out  WIDTH  data at selected tap
- VOUT  out  1  valid at selected tap
- PRIMED  out  1  selected tap holds post-reset/post-flush data

## Operation
- Storage: data stages d[1..MAX_DEPTH] (WIDTH bits each), valid stages v[1..MAX_DEPTH], fill counter fill (LW bits, saturating at MAX_DEPTH).
- rst high, asynchronous: all d[i] = RST_VAL, all v[i] = 0, fill = 0. Held while rst is high.
- Clock edge priority: FLUSH, then EN.
- FLUSH=1: d[i] = RST_VAL, v[i] = 0, fill = 0, regardless of EN. DIN/VIN on that cycle are discarded.
- FLUSH=0, EN=1: d[1]=DIN, v[1]=VIN, d[i]=d[i-1], v[i]=v[i-1] for i>1; fill = min(fill+1, MAX_DEPTH).
- FLUSH=0, EN=0: all state holds, including fill.
- Tap select, combinational: L = min(LAT, MAX_DEPTH). Out-of-range LAT clamps to MAX_DEPTH.
  - L=0: DOUT=DIN, VOUT=VIN, PRIMED=1 (pure bypass, no register in path).
  - L≥1: DOUT=d[L], VOUT=v[L], PRIMED=(fill ≥ L).
- LAT change: takes effect combinationally on the same cycle; no state is altered. Raising LAT may expose stages with v=0 or RST_VAL, and PRIMED drops accordingly. Lowering LAT exposes younger data.
- VOUT and PRIMED are independent. VOUT tracks VIN propagation; PRIMED tracks only EN cycles since clear.

## Timing
- Latency: exactly L EN-qualified rising edges from DIN to DOUT. Stall cycles (EN=0) do not count.
- Outputs immediately after reset deassertion (L≥1): DOUT=RST_VAL, VOUT=0, PRIMED=0. With L=0 they follow DIN/VIN, and PRIMED=1.
- After FLUSH edge, L≥1: DOUT=RST_VAL, VOUT=0, PRIMED=0 on the next cycle. PRIMED rises after L further EN edges.
- FLUSH and EN high together: flush wins, fill = 0, not 1.
- fill saturates at MAX_DEPTH and never wraps.
- rst asserted mid-stream: clears state immediately, without waiting for clk. On release, the first EN edge loads DIN into d[1].
- No combinational path from DIN/VIN to outputs except when L=0. LAT→outputs is always combinational (mux).

## Test plan
- Reset/fill: MAX_DEPTH=4, LAT=3, EN=1, DIN=1,2,3,… with VIN=1 after rst release. DOUT=0, VOUT=0, PRIMED=0 for 3 cycles. Then DOUT=1, VOUT=1, PRIMED=1, with the sequence continuing +1 per cycle.
- Stall: LAT=2, stream 10,11,12; hold EN=0 for 3 cycles after 11 enters d[1]. DOUT freezes at 10 and fill stays constant. On resume, DOUT becomes 11 then 12 with no loss or duplication.
- Flush priority: mid-stream with LAT=4, assert FLUSH=1 and EN=1 together. Next cycle DOUT=RST_VAL, VOUT=0, PRIMED=0. PRIMED returns exactly 4 EN edges later.
- Bypass and clamp: LAT=0 with DIN=0x2A, VIN=1 gives DOUT=0x2A, VOUT=1, PRIMED=1 in the same cycle. LAT=7 with MAX_DEPTH=4 behaves identically to LAT=4.
- Runtime LAT change: after 4 primed cycles of stream 20,21,…, switch LAT 1→4. DOUT jumps to the d[4] value, 3 lower than the previous DOUT, in the same cycle, and PRIMED stays 1.
- Async reset mid-operation: pulse rst between clock edges while VOUT=1. DOUT=RST_VAL, VOUT=0, PRIMED=0 before the next clk edge.
